fb_swap_ctrl: RTL and testbench

FB_SWAP_CTRL -- requirements
Module: fb_swap_ctrl

---
 rtl/fb_swap_ctrl_if.sv | 30 +++
 rtl/fb_swap_ctrl.sv | 108 ++++++++++
 tb/tb_fb_swap_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fb_swap_ctrl_if.sv
// Ray-caster / frame-buffer control bundle between the sweep source and the swap controller.
// slave = controller side, master = ray caster / video timing side.
interface fb_swap_ctrl_if #(
    parameter int STAT_WIDTH = 16
);
    logic                  ray_valid_in;
    logic [15:0]           ray_address_in;
    logic                  ray_last_pixel_in;
    logic                  video_last_pixel_in;
    logic                  render_start_out;
    logic                  fb_wr_en_out;
    logic                  fb_wr_sel_out;
    logic                  fb_rd_sel_out;
    logic                  swap_out;
    logic [1:0]            state_out;
    logic [STAT_WIDTH-1:0] frames_rendered_out;
    logic [STAT_WIDTH-1:0] frames_repeated_out;

    modport slave (
        input  ray_valid_in, ray_address_in, ray_last_pixel_in, video_last_pixel_in,
        output render_start_out, fb_wr_en_out, fb_wr_sel_out, fb_rd_sel_out,
               swap_out, state_out, frames_rendered_out, frames_repeated_out
    );

    modport master (
        output ray_valid_in, ray_address_in, ray_last_pixel_in, video_last_pixel_in,
        input  render_start_out, fb_wr_en_out, fb_wr_sel_out, fb_rd_sel_out,
               swap_out, state_out, frames_rendered_out, frames_repeated_out
    );
endinterface

// File: rtl/fb_swap_ctrl.sv
// Double-buffer swap controller: ray caster fills one buffer while video shows the other; swap at vsync.
// Latency: write enable is combinational; state/selects/pulses registered (1 cycle). No backpressure.
// FB_SWAP_STATS_EN adds saturating rendered/repeated frame counters; otherwise they read as 0.
module fb_swap_ctrl #(
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 180,
    parameter int STAT_WIDTH    = 16
) (
    input  logic              pixel_clk_in,
    input  logic              rst_in,
    fb_swap_ctrl_if.slave     bus
);
    localparam logic [31:0] FB_PIXELS = 32'(SCREEN_WIDTH * SCREEN_HEIGHT);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RENDER     = 2'd1,
        WAIT_VSYNC = 2'd2,
        SWAP       = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   wr_sel_q, wr_sel_d;
    logic   render_start_q, render_start_d;

    always_comb begin
        state_d        = state_q;
        wr_sel_d       = wr_sel_q;
        render_start_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d        = RENDER;
                render_start_d = 1'b1;
            end
            RENDER: begin
                if (bus.ray_last_pixel_in) begin
                    state_d = bus.video_last_pixel_in ? SWAP : WAIT_VSYNC;
                end
            end
            WAIT_VSYNC: begin
                if (bus.video_last_pixel_in) begin
                    state_d = SWAP;
                end
            end
            SWAP: begin
                state_d        = RENDER;
                wr_sel_d       = ~wr_sel_q;
                render_start_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q        <= IDLE;
            wr_sel_q       <= 1'b0;
            render_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_sel_q       <= wr_sel_d;
            render_start_q <= render_start_d;
        end
    end

    // The last pixel of a sweep is still a normal write, so only state and range gate it.
    assign bus.fb_wr_en_out     = bus.ray_valid_in && (state_q == RENDER) &&
                                  ({16'd0, bus.ray_address_in} < FB_PIXELS);
    assign bus.fb_wr_sel_out    = wr_sel_q;
    assign bus.fb_rd_sel_out    = ~wr_sel_q;
    assign bus.swap_out         = (state_q == SWAP);
    assign bus.state_out        = state_q;
    assign bus.render_start_out = render_start_q;

`ifdef FB_SWAP_STATS_EN
    logic [STAT_WIDTH-1:0] rendered_q, rendered_d;
    logic [STAT_WIDTH-1:0] repeated_q, repeated_d;

    always_comb begin
        rendered_d = rendered_q;
        repeated_d = repeated_q;
        if (state_q == RENDER) begin
            if (bus.ray_last_pixel_in) begin
                if (rendered_q != '1) rendered_d = rendered_q + 1'b1;
            end else if (bus.video_last_pixel_in) begin
                // Display wrapped with no fresh buffer: the old frame is shown again.
                if (repeated_q != '1) repeated_d = repeated_q + 1'b1;
            end
        end
    end

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rendered_q <= '0;
            repeated_q <= '0;
        end else begin
            rendered_q <= rendered_d;
            repeated_q <= repeated_d;
        end
    end

    assign bus.frames_rendered_out = rendered_q;
    assign bus.frames_repeated_out = repeated_q;
`else
    assign bus.frames_rendered_out = '0;
    assign bus.frames_repeated_out = '0;
`endif
endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Directed bench for fb_swap_ctrl; inputs driven and outputs sampled on the falling clock edge.
module tb_fb_swap_ctrl;
    localparam int STAT_WIDTH = 16;

`ifdef FB_SWAP_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fb_swap_ctrl_if #(.STAT_WIDTH(STAT_WIDTH)) bus ();

    fb_swap_ctrl #(
        .SCREEN_WIDTH (320),
        .SCREEN_HEIGHT(180),
        .STAT_WIDTH   (STAT_WIDTH)
    ) dut (
        .pixel_clk_in(clk),
        .rst_in      (rst_n),
        .bus         (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"},    32'(bus.state_out), 0);
        chk({tag, "_wr_sel"},   32'(bus.fb_wr_sel_out), 0);
        chk({tag, "_rd_sel"},   32'(bus.fb_rd_sel_out), 1);
        chk({tag, "_rstart"},   32'(bus.render_start_out), 0);
        chk({tag, "_swap"},     32'(bus.swap_out), 0);
        chk({tag, "_rendered"}, 32'(bus.frames_rendered_out), 0);
        chk({tag, "_repeated"}, 32'(bus.frames_repeated_out), 0);
    endtask

    task automatic pulse_video;
        bus.video_last_pixel_in = 1'b1;
        @(negedge clk);
        bus.video_last_pixel_in = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.ray_valid_in        = 1'b0;
        bus.ray_address_in      = 16'd0;
        bus.ray_last_pixel_in   = 1'b0;
        bus.video_last_pixel_in = 1'b0;

        #1;
        chk_reset_vals("rst0");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("idle_before_edge", 32'(bus.state_out), 0);
        @(negedge clk);
        chk("enter_render",  32'(bus.state_out), 1);
        chk("rstart_pulse",  32'(bus.render_start_out), 1);
        chk("init_wr_sel",   32'(bus.fb_wr_sel_out), 0);
        chk("init_rd_sel",   32'(bus.fb_rd_sel_out), 1);
        @(negedge clk);
        chk("rstart_1cyc",   32'(bus.render_start_out), 0);

        // Address range boundary.
        bus.ray_valid_in = 1'b1;
        bus.ray_address_in = 16'd57599; #1;
        chk("wr_en_57599", 32'(bus.fb_wr_en_out), 1);
        bus.ray_address_in = 16'd57600; #1;
        chk("wr_en_57600", 32'(bus.fb_wr_en_out), 0);
        bus.ray_address_in = 16'd65535; #1;
        chk("wr_en_65535", 32'(bus.fb_wr_en_out), 0);
        bus.ray_valid_in = 1'b0;
        bus.ray_address_in = 16'd100; #1;
        chk("wr_en_novalid", 32'(bus.fb_wr_en_out), 0);

        // Two repeated frames while rendering.
        @(negedge clk);
        pulse_video();
        chk("stay_render_v1", 32'(bus.state_out), 1);
        pulse_video();
        chk("stay_render_v2", 32'(bus.state_out), 1);
        chk("repeated_2",     32'(bus.frames_repeated_out), 32'(2 * STATS));
        chk("rendered_0",     32'(bus.frames_rendered_out), 0);

        // Last pixel, with its write still accepted.
        bus.ray_valid_in = 1'b1;
        bus.ray_last_pixel_in = 1'b1; #1;
        chk("wr_en_last_px", 32'(bus.fb_wr_en_out), 1);
        @(negedge clk);
        bus.ray_last_pixel_in = 1'b0;
        chk("rendered_1",    32'(bus.frames_rendered_out), 32'(STATS));
        chk("wr_en_wait",    32'(bus.fb_wr_en_out), 0);
        bus.ray_valid_in = 1'b0;

        // Ten cycles in WAIT_VSYNC; a stray last-pixel pulse is ignored.
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("wait_%0d", i), 32'(bus.state_out), 2);
            bus.ray_last_pixel_in = (i == 3);
            bus.video_last_pixel_in = (i == 9);
            @(negedge clk);
        end
        bus.ray_last_pixel_in = 1'b0;
        bus.video_last_pixel_in = 1'b0;
        chk("swap_state",      32'(bus.state_out), 3);
        chk("swap_out",        32'(bus.swap_out), 1);
        chk("swap_wr_sel",     32'(bus.fb_wr_sel_out), 0);
        chk("rendered_ignore", 32'(bus.frames_rendered_out), 32'(STATS));
        @(negedge clk);
        chk("post_swap_state", 32'(bus.state_out), 1);
        chk("post_swap_wr",    32'(bus.fb_wr_sel_out), 1);
        chk("post_swap_rd",    32'(bus.fb_rd_sel_out), 0);
        chk("post_swap_start", 32'(bus.render_start_out), 1);
        chk("post_swap_noswp", 32'(bus.swap_out), 0);

        // Last pixel coincident with vsync: straight to SWAP.
        bus.ray_last_pixel_in = 1'b1;
        bus.video_last_pixel_in = 1'b1;
        @(negedge clk);
        bus.ray_last_pixel_in = 1'b0;
        bus.video_last_pixel_in = 1'b0;
        chk("direct_swap",   32'(bus.state_out), 3);
        chk("repeated_keep", 32'(bus.frames_repeated_out), 32'(2 * STATS));
        @(negedge clk);
        chk("direct_render", 32'(bus.state_out), 1);
        chk("direct_wr_sel", 32'(bus.fb_wr_sel_out), 0);
        chk("rendered_2",    32'(bus.frames_rendered_out), 32'(2 * STATS));

        // Get back to wr_sel=1 and park in WAIT_VSYNC, then reset.
        bus.ray_last_pixel_in = 1'b1;
        bus.video_last_pixel_in = 1'b1;
        @(negedge clk);
        bus.video_last_pixel_in = 1'b0;
        bus.ray_last_pixel_in = 1'b0;
        @(negedge clk);
        bus.ray_last_pixel_in = 1'b1;
        @(negedge clk);
        bus.ray_last_pixel_in = 1'b0;
        chk("pre_rst_state",  32'(bus.state_out), 2);
        chk("pre_rst_wr_sel", 32'(bus.fb_wr_sel_out), 1);
        rst_n = 1'b0; #1;
        chk_reset_vals("rst_wait");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_state",  32'(bus.state_out), 1);
        chk("restart_rstart", 32'(bus.render_start_out), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
